// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I/M control FSM with datapath selects and retire counter
// Enables come from the state register plus the held instruction; selects decode inst_i alone.
module multicycle_ctrl #(
  parameter bit MEXT_EN = 1'b1,
  parameter bit MEM_HS  = 1'b1,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      inst_i,
  input  logic             BrEq_i,
  input  logic             BrLt_i,
  input  logic             mem_ready_i,
  input  logic             mdu_done_i,
  output logic             PCWEn_o,
  output logic             IRWEn_o,
  output logic             RegWEn_o,
  output logic             MemRd_o,
  output logic             MemWr_o,
  output logic [3:0]       AluSel_o,
  output logic [2:0]       ImmSel_o,
  output logic [1:0]       WBSel_o,
  output logic             Asel_o,
  output logic             Bsel_o,
  output logic             BrUn_o,
  output logic             PCSel_o,
  output logic             mdu_start_o,
  output logic [2:0]       state_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MDU    = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_REG    = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  state_t state_q, state_n;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
  logic       is_opimm, is_op, is_fence, is_system, is_mop, is_rv32i, is_illegal;
  logic       mem_done, br_taken;
  logic       pcwen, irwen, regwen, memrd, memwr, pcsel, mdu_start;
  logic       unused_inst_bits;

  assign opcode    = inst_i[6:0];
  assign rd        = inst_i[11:7];
  assign funct3    = inst_i[14:12];
  assign funct7    = inst_i[31:25];
  assign unused_inst_bits = ^inst_i[24:15];

  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_opimm  = (opcode == OPC_IMM);
  assign is_op     = (opcode == OPC_REG);
  assign is_fence  = (opcode == OPC_FENCE);
  assign is_system = (opcode == OPC_SYSTEM);
  assign is_mop    = is_op && (funct7 == 7'b0000001);
  assign is_rv32i  = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store |
                     is_opimm | is_op | is_fence | is_system;
  assign is_illegal = !is_rv32i || (is_mop && !MEXT_EN);

  // Without a handshake every memory phase is treated as finishing in its first cycle.
  assign mem_done = !MEM_HS || mem_ready_i;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:          br_taken = BrEq_i;
      3'b001:          br_taken = !BrEq_i;
      3'b100, 3'b110:  br_taken = BrLt_i;
      3'b101, 3'b111:  br_taken = !BrLt_i;
      default:         br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n   = state_q;
    pcwen     = 1'b0;
    irwen     = 1'b0;
    regwen    = 1'b0;
    memrd     = 1'b0;
    memwr     = 1'b0;
    pcsel     = 1'b0;
    mdu_start = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwen = 1'b1;
        if (mem_done) state_n = S_DECODE;
      end
      S_DECODE: begin
        if (is_illegal) begin
          state_n = S_TRAP;
        end else if (is_mop) begin
          mdu_start = 1'b1;
          state_n   = S_MDU;
        end else begin
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          pcwen   = 1'b1;
          pcsel   = br_taken;
          state_n = S_FETCH;
        end else if (is_jal || is_jalr) begin
          regwen  = 1'b1;
          pcsel   = 1'b1;
          pcwen   = 1'b1;
          state_n = S_FETCH;
        end else if (is_load || is_store) begin
          state_n = S_MEM;
        end else begin
          state_n = S_WB;
        end
      end
      S_MEM: begin
        memrd = is_load;
        memwr = is_store;
        if (mem_done) begin
          if (is_store) begin
            pcwen   = 1'b1;
            state_n = S_FETCH;
          end else begin
            state_n = S_WB;
          end
        end
      end
      S_WB: begin
        regwen  = 1'b1;
        pcwen   = 1'b1;
        state_n = S_FETCH;
      end
      S_MDU: begin
        if (mdu_done_i) begin
          regwen  = 1'b1;
          pcwen   = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_TRAP:  state_n = S_TRAP;
      default: state_n = S_FETCH;
    endcase
  end

  // Reset masks every enable combinationally so nothing commits in the reset cycle.
  assign PCWEn_o     = pcwen && !rst_i;
  assign IRWEn_o     = irwen && !rst_i;
  assign RegWEn_o    = regwen && (rd != 5'd0) && !rst_i;
  assign MemRd_o     = memrd && !rst_i;
  assign MemWr_o     = memwr && !rst_i;
  assign PCSel_o     = pcsel;
  assign mdu_start_o = mdu_start && !rst_i;
  assign state_o     = state_q;
  assign illegal_o   = (state_q == S_TRAP);

  always_comb begin
    AluSel_o = {inst_i[30], funct3};
    if (is_branch || is_jal || is_jalr || is_load || is_store || is_auipc ||
        (is_opimm && funct3 == 3'b000))
      AluSel_o = 4'b0000;
    else if (is_lui)
      AluSel_o = 4'b1111;

    ImmSel_o = 3'b111;
    if (is_opimm || is_load || is_jalr || is_fence || is_system) ImmSel_o = 3'b000;
    else if (is_store)                                             ImmSel_o = 3'b001;
    else if (is_branch)                                            ImmSel_o = 3'b010;
    else if (is_jal)                                               ImmSel_o = 3'b011;
    else if (is_lui || is_auipc)                                   ImmSel_o = 3'b100;

    WBSel_o = 2'b01;
    if (is_load)                WBSel_o = 2'b00;
    else if (is_jal || is_jalr) WBSel_o = 2'b10;
    else if (is_mop)            WBSel_o = 2'b11;
  end

  assign Asel_o = is_branch || is_jal || is_auipc;
  assign Bsel_o = !is_op;
  assign BrUn_o = is_branch && (funct3[2:1] == 2'b11);

  always_ff @(posedge clk_i) begin
    if (rst_i)        retire_cnt_o <= '0;
    else if (PCWEn_o) retire_cnt_o <= retire_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
// Four instances cover the handshake, M-extension and counter-width variants.
module tb_multicycle_ctrl;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_REG    = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst, breq, brlt, mem_ready, mdu_done;
  logic [31:0] inst;

  logic       a_pcwen, a_irwen, a_regwen, a_memrd, a_memwr, a_asel, a_bsel, a_brun, a_pcsel, a_start, a_ill;
  logic [3:0] a_alu;  logic [2:0] a_imm, a_st;  logic [1:0] a_wb;  logic [31:0] a_cnt;
  logic       b_pcwen, b_irwen, b_regwen, b_memrd, b_memwr, b_asel, b_bsel, b_brun, b_pcsel, b_start, b_ill;
  logic [3:0] b_alu;  logic [2:0] b_imm, b_st;  logic [1:0] b_wb;  logic [31:0] b_cnt;
  logic       c_pcwen, c_irwen, c_regwen, c_memrd, c_memwr, c_asel, c_bsel, c_brun, c_pcsel, c_start, c_ill;
  logic [3:0] c_alu;  logic [2:0] c_imm, c_st;  logic [1:0] c_wb;  logic [31:0] c_cnt;
  logic       d_pcwen, d_irwen, d_regwen, d_memrd, d_memwr, d_asel, d_bsel, d_brun, d_pcsel, d_start, d_ill;
  logic [3:0] d_alu;  logic [2:0] d_imm, d_st;  logic [1:0] d_wb;  logic [3:0] d_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEXT_EN(1'b1), .MEM_HS(1'b0), .CNT_W(32)) dut_a (
    .clk_i(clk), .rst_i(rst), .inst_i(inst), .BrEq_i(breq), .BrLt_i(brlt),
    .mem_ready_i(mem_ready), .mdu_done_i(mdu_done),
    .PCWEn_o(a_pcwen), .IRWEn_o(a_irwen), .RegWEn_o(a_regwen), .MemRd_o(a_memrd), .MemWr_o(a_memwr),
    .AluSel_o(a_alu), .ImmSel_o(a_imm), .WBSel_o(a_wb), .Asel_o(a_asel), .Bsel_o(a_bsel),
    .BrUn_o(a_brun), .PCSel_o(a_pcsel), .mdu_start_o(a_start), .state_o(a_st),
    .illegal_o(a_ill), .retire_cnt_o(a_cnt));

  multicycle_ctrl #(.MEXT_EN(1'b1), .MEM_HS(1'b1), .CNT_W(32)) dut_b (
    .clk_i(clk), .rst_i(rst), .inst_i(inst), .BrEq_i(breq), .BrLt_i(brlt),
    .mem_ready_i(mem_ready), .mdu_done_i(mdu_done),
    .PCWEn_o(b_pcwen), .IRWEn_o(b_irwen), .RegWEn_o(b_regwen), .MemRd_o(b_memrd), .MemWr_o(b_memwr),
    .AluSel_o(b_alu), .ImmSel_o(b_imm), .WBSel_o(b_wb), .Asel_o(b_asel), .Bsel_o(b_bsel),
    .BrUn_o(b_brun), .PCSel_o(b_pcsel), .mdu_start_o(b_start), .state_o(b_st),
    .illegal_o(b_ill), .retire_cnt_o(b_cnt));

  multicycle_ctrl #(.MEXT_EN(1'b0), .MEM_HS(1'b0), .CNT_W(32)) dut_c (
    .clk_i(clk), .rst_i(rst), .inst_i(inst), .BrEq_i(breq), .BrLt_i(brlt),
    .mem_ready_i(mem_ready), .mdu_done_i(mdu_done),
    .PCWEn_o(c_pcwen), .IRWEn_o(c_irwen), .RegWEn_o(c_regwen), .MemRd_o(c_memrd), .MemWr_o(c_memwr),
    .AluSel_o(c_alu), .ImmSel_o(c_imm), .WBSel_o(c_wb), .Asel_o(c_asel), .Bsel_o(c_bsel),
    .BrUn_o(c_brun), .PCSel_o(c_pcsel), .mdu_start_o(c_start), .state_o(c_st),
    .illegal_o(c_ill), .retire_cnt_o(c_cnt));

  multicycle_ctrl #(.MEXT_EN(1'b1), .MEM_HS(1'b0), .CNT_W(4)) dut_d (
    .clk_i(clk), .rst_i(rst), .inst_i(inst), .BrEq_i(breq), .BrLt_i(brlt),
    .mem_ready_i(mem_ready), .mdu_done_i(mdu_done),
    .PCWEn_o(d_pcwen), .IRWEn_o(d_irwen), .RegWEn_o(d_regwen), .MemRd_o(d_memrd), .MemWr_o(d_memwr),
    .AluSel_o(d_alu), .ImmSel_o(d_imm), .WBSel_o(d_wb), .Asel_o(d_asel), .Bsel_o(d_bsel),
    .BrUn_o(d_brun), .PCSel_o(d_pcsel), .mdu_start_o(d_start), .state_o(d_st),
    .illegal_o(d_ill), .retire_cnt_o(d_cnt));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; inst = 32'h0000_0013; breq = 0; brlt = 0; mem_ready = 0; mdu_done = 0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; inst = 32'h0000_0013; breq = 0; brlt = 0; mem_ready = 0; mdu_done = 0;
    step();
    for (int k = 0; k < 3; k++) begin
      inst = (k == 0) ? 32'h0000_0013 : 32'h00c0_006f;
      mem_ready = 1'b1; mdu_done = 1'b1; breq = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({a_st, a_ill, a_cnt} !== {3'd0, 1'b0, 32'd0}) begin
        failures++; $display("FAIL reset_state k=%0d got st=%0d ill=%0b cnt=%0d exp 0/0/0", k, a_st, a_ill, a_cnt);
      end
      checks++;
      if ({a_pcwen, a_irwen, a_regwen, a_memrd, a_memwr, a_start, b_irwen, d_irwen} !== 8'b0) begin
        failures++; $display("FAIL reset_enables k=%0d got %b exp 00000000", k,
          {a_pcwen, a_irwen, a_regwen, a_memrd, a_memwr, a_start, b_irwen, d_irwen});
      end
      step();
    end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    int exp_st [5] = '{0, 1, 2, 4, 0};
    do_reset();
    inst = 32'h0050_0093;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (a_st !== 3'(exp_st[k])) begin
        failures++; $display("FAIL addi_state k=%0d got %0d exp %0d", k, a_st, exp_st[k]);
      end
      if (k == 3) begin
        checks++;
        if ({a_regwen, a_pcwen, a_wb} !== 4'b1101) begin
          failures++; $display("FAIL addi_wb got regwen=%0b pcwen=%0b wbsel=%b exp 1 1 01", a_regwen, a_pcwen, a_wb);
        end
      end
      if (k == 0 || k == 4) begin
        checks++;
        if (a_cnt !== ((k == 4) ? 32'd1 : 32'd0)) begin
          failures++; $display("FAIL addi_retire k=%0d got %0d exp %0d", k, a_cnt, (k == 4) ? 1 : 0);
        end
      end
      step();
    end
  endtask

  task automatic test_branch();
    for (int t = 0; t < 2; t++) begin
      do_reset();
      inst = 32'h0000_0063; breq = (t == 0); brlt = 1'($urandom_range(0, 1));
      step(); step();
      @(negedge clk);
      checks++;
      if ({a_st, a_pcwen, a_pcsel, a_brun} !== {3'd2, 1'b1, (t == 0), 1'b0}) begin
        failures++; $display("FAIL branch_beq breq=%0d got st=%0d pcwen=%0b pcsel=%0b brun=%0b exp 2 1 %0d 0",
          (t == 0), a_st, a_pcwen, a_pcsel, a_brun, (t == 0));
      end
      step();
    end
  endtask

  task automatic test_load_hs();
    int rd_cycles = 0;
    do_reset();
    inst = 32'h0000_2103; mem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({b_st, b_irwen} !== {3'd0, 1'b1}) begin
        failures++; $display("FAIL lw_fetch_wait k=%0d got st=%0d irwen=%0b exp 0 1", k, b_st, b_irwen);
      end
      step();
    end
    mem_ready = 1'b1;
    step(); step(); step();
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      @(negedge clk);
      if (b_st == 3'd3 && b_memrd) rd_cycles++;
      checks++;
      if ({b_pcwen, b_regwen, b_memwr} !== 3'b000) begin
        failures++; $display("FAIL lw_mem_enables k=%0d got %b exp 000", k, {b_pcwen, b_regwen, b_memwr});
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (rd_cycles !== 4) begin
      failures++; $display("FAIL lw_memrd_cycles got %0d exp 4", rd_cycles);
    end
    checks++;
    if ({b_st, b_wb, b_regwen, b_pcwen, b_pcsel} !== {3'd4, 2'b00, 1'b1, 1'b1, 1'b0}) begin
      failures++; $display("FAIL lw_wb got st=%0d wb=%b regwen=%0b pcwen=%0b pcsel=%0b exp 4 00 1 1 0",
        b_st, b_wb, b_regwen, b_pcwen, b_pcsel);
    end
    step();
    @(negedge clk);
    checks++;
    if ({b_st, b_cnt} !== {3'd0, 32'd1}) begin
      failures++; $display("FAIL lw_retire got st=%0d cnt=%0d exp 0 1", b_st, b_cnt);
    end
  endtask

  task automatic test_mul();
    int a_pulses = 0;
    int c_pulses = 0;
    do_reset();
    inst = 32'h0220_81B3;
    for (int k = 0; k < 8; k++) begin
      mdu_done = (k == 7);
      @(negedge clk);
      if (a_start) a_pulses++;
      if (c_start) c_pulses++;
      if (k == 7) begin
        checks++;
        if ({a_st, a_regwen, a_wb, a_pcwen} !== {3'd5, 1'b1, 2'b11, 1'b1}) begin
          failures++; $display("FAIL mul_done got st=%0d regwen=%0b wb=%b pcwen=%0b exp 5 1 11 1",
            a_st, a_regwen, a_wb, a_pcwen);
        end
      end else if (k >= 2) begin
        checks++;
        if ({a_st, a_pcwen, a_regwen} !== {3'd5, 1'b0, 1'b0}) begin
          failures++; $display("FAIL mul_wait k=%0d got st=%0d pcwen=%0b regwen=%0b exp 5 0 0", k, a_st, a_pcwen, a_regwen);
        end
        checks++;
        if ({c_st, c_ill} !== {3'd6, 1'b1}) begin
          failures++; $display("FAIL mul_noext_trap k=%0d got st=%0d ill=%0b exp 6 1", k, c_st, c_ill);
        end
      end
      step();
    end
    mdu_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_pulses, c_pulses} !== {32'd1, 32'd0}) begin
      failures++; $display("FAIL mul_start_pulses got a=%0d c=%0d exp 1 0", a_pulses, c_pulses);
    end
    checks++;
    if ({a_st, a_cnt} !== {3'd0, 32'd1}) begin
      failures++; $display("FAIL mul_retire got st=%0d cnt=%0d exp 0 1", a_st, a_cnt);
    end
  endtask

  task automatic test_trap();
    do_reset();
    inst = 32'h0050_0093;
    repeat (4) step();
    inst = 32'h0000_0000;
    step(); step();
    for (int k = 0; k < 10; k++) begin
      mem_ready = 1'($urandom_range(0, 1)); mdu_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({a_st, a_ill, a_pcwen, a_irwen, a_regwen, a_memrd, a_memwr, a_start, a_cnt} !==
          {3'd6, 1'b1, 6'b0, 32'd1}) begin
        failures++; $display("FAIL trap_hold k=%0d got st=%0d ill=%0b en=%b cnt=%0d exp 6 1 000000 1", k, a_st, a_ill,
          {a_pcwen, a_irwen, a_regwen, a_memrd, a_memwr, a_start}, a_cnt);
      end
      step();
    end
    rst = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if ({a_st, a_ill, a_cnt} !== {3'd0, 1'b0, 32'd0}) begin
      failures++; $display("FAIL trap_reset got st=%0d ill=%0b cnt=%0d exp 0 0 0", a_st, a_ill, a_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_midop();
    do_reset();
    inst = 32'h0000_2103; mem_ready = 1'b1;
    step(); step(); step();
    mem_ready = 1'b0;
    step();
    rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({b_st, b_memrd, b_pcwen, b_regwen} !== {3'd3, 3'b000}) begin
      failures++; $display("FAIL rst_in_mem got st=%0d memrd=%0b pcwen=%0b regwen=%0b exp 3 0 0 0",
        b_st, b_memrd, b_pcwen, b_regwen);
    end
    step();
    @(negedge clk);
    checks++;
    if ({b_st, b_cnt} !== {3'd0, 32'd0}) begin
      failures++; $display("FAIL rst_from_mem got st=%0d cnt=%0d exp 0 0", b_st, b_cnt);
    end
    rst = 1'b0;
    do_reset();
    inst = 32'h0050_0093;
    repeat (4) step();
    inst = 32'h0220_81B3; mdu_done = 1'b0;
    repeat (4) step();
    rst = 1'b1; mdu_done = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_st, a_cnt, a_regwen, a_pcwen} !== {3'd5, 32'd1, 2'b00}) begin
      failures++; $display("FAIL rst_in_mdu got st=%0d cnt=%0d regwen=%0b pcwen=%0b exp 5 1 0 0",
        a_st, a_cnt, a_regwen, a_pcwen);
    end
    step();
    @(negedge clk);
    checks++;
    if ({a_st, a_cnt} !== {3'd0, 32'd0}) begin
      failures++; $display("FAIL rst_from_mdu got st=%0d cnt=%0d exp 0 0", a_st, a_cnt);
    end
    rst = 1'b0; mdu_done = 1'b0;
  endtask

  task automatic test_wrap();
    int n_ret = 17;
    do_reset();
    inst = 32'h0050_0093;
    repeat (n_ret * 4) step();
    @(negedge clk);
    checks++;
    if (d_cnt !== 4'(n_ret % 16)) begin
      failures++; $display("FAIL wrap_cnt4 got %0d exp %0d", d_cnt, n_ret % 16);
    end
    checks++;
    if (a_cnt !== 32'(n_ret)) begin
      failures++; $display("FAIL wrap_cnt32 got %0d exp %0d", a_cnt, n_ret);
    end
  endtask

  // Reference: each instruction class has a fixed state walk (MEM_HS=0) and a fixed set of
  // effects in its final cycle; everything is derived from the instruction class, not the RTL.
  task automatic test_random();
    logic [6:0] ill_opc [6] = '{7'h00, 7'h7f, 7'h0b, 7'h2b, 7'h5b, 7'h77};
    logic [2:0] br_f3 [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    int model_cnt = 0;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int c, waitc, last;
      int path[$];
      logic [31:0] ins;
      logic [6:0] op;
      logic [2:0] f3;
      logic taken, exp_rw, exp_ps, exp_asel, exp_bsel, is_last;
      logic [3:0] exp_alu;
      logic [2:0] exp_imm;
      logic [1:0] exp_wb;
      c = $urandom_range(0, 7);
      ins = $urandom;
      case (c)
        0: case ($urandom_range(0, 3))
             0: ins[6:0] = OPC_IMM;
             1: begin ins[6:0] = OPC_REG; ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0; end
             2: ins[6:0] = OPC_LUI;
             default: ins[6:0] = OPC_AUIPC;
           endcase
        1: ins[6:0] = OPC_LOAD;
        2: ins[6:0] = OPC_STORE;
        3: begin ins[6:0] = OPC_BRANCH; ins[14:12] = br_f3[$urandom_range(0, 5)]; end
        4: ins[6:0] = OPC_JAL;
        5: ins[6:0] = OPC_JALR;
        6: begin ins[6:0] = OPC_REG; ins[31:25] = 7'b0000001; end
        default: ins[6:0] = ill_opc[$urandom_range(0, 5)];
      endcase
      if ($urandom_range(0, 4) == 0) ins[11:7] = 5'd0;
      op = ins[6:0]; f3 = ins[14:12];
      breq = 1'($urandom_range(0, 1)); brlt = 1'($urandom_range(0, 1));
      case (f3)
        3'b000: taken = breq;
        3'b001: taken = !breq;
        3'b100, 3'b110: taken = brlt;
        default: taken = !brlt;
      endcase
      exp_rw   = (c inside {0, 1, 4, 5, 6}) && (ins[11:7] != 5'd0);
      exp_ps   = (c == 3) ? taken : (c == 4 || c == 5);
      exp_wb   = (c == 1) ? 2'b00 : (c == 4 || c == 5) ? 2'b10 : (c == 6) ? 2'b11 : 2'b01;
      exp_asel = (c == 3) || (c == 4) || (op == OPC_AUIPC);
      exp_bsel = (op != OPC_REG);
      if ((c inside {1, 2, 3, 4, 5}) || op == OPC_AUIPC || (op == OPC_IMM && f3 == 3'b000)) exp_alu = 4'b0000;
      else if (op == OPC_LUI) exp_alu = 4'b1111;
      else exp_alu = {ins[30], f3};
      case (c)
        1, 5: exp_imm = 3'b000;
        2: exp_imm = 3'b001;
        3: exp_imm = 3'b010;
        4: exp_imm = 3'b011;
        6: exp_imm = 3'b111;
        default: exp_imm = (op == OPC_IMM) ? 3'b000 : (op == OPC_REG) ? 3'b111 : 3'b100;
      endcase
      path = {};
      case (c)
        0: path = {0, 1, 2, 4};
        1: path = {0, 1, 2, 3, 4};
        2: path = {0, 1, 2, 3};
        3, 4, 5: path = {0, 1, 2};
        6: begin
          path = {0, 1};
          waitc = $urandom_range(0, 6);
          repeat (waitc + 1) path.push_back(5);
        end
        default: path = {0, 1, 6, 6, 6};
      endcase
      last = path.size() - 1;
      inst = ins;
      for (int k = 0; k <= last; k++) begin
        mem_ready = 1'($urandom_range(0, 1));
        mdu_done = (path[k] == 5) ? (k == last) : 1'($urandom_range(0, 1));
        is_last = (k == last) && (c != 7);
        @(negedge clk);
        if (k == 0) begin
          checks++;
          if (a_cnt !== 32'(model_cnt)) begin
            failures++; $display("FAIL rand_retire n=%0d got %0d exp %0d", n, a_cnt, model_cnt);
          end
        end
        checks++;
        if (a_st !== 3'(path[k])) begin
          failures++; $display("FAIL rand_state n=%0d inst=%h k=%0d got %0d exp %0d", n, ins, k, a_st, path[k]);
        end
        checks++;
        if ({a_pcwen, a_regwen, a_irwen, a_memrd, a_memwr, a_start, a_ill} !==
            {is_last, is_last && exp_rw, path[k] == 0, path[k] == 3 && c == 1, path[k] == 3 && c == 2,
             k == 1 && c == 6, path[k] == 6}) begin
          failures++; $display("FAIL rand_enables n=%0d inst=%h k=%0d got %b exp %b", n, ins, k,
            {a_pcwen, a_regwen, a_irwen, a_memrd, a_memwr, a_start, a_ill},
            {is_last, is_last && exp_rw, path[k] == 0, path[k] == 3 && c == 1, path[k] == 3 && c == 2,
             k == 1 && c == 6, path[k] == 6});
        end
        if (is_last) begin
          checks++;
          if (a_pcsel !== exp_ps) begin
            failures++; $display("FAIL rand_pcsel n=%0d inst=%h got %0b exp %0b", n, ins, a_pcsel, exp_ps);
          end
          if (c inside {0, 1, 4, 5, 6}) begin
            checks++;
            if (a_wb !== exp_wb) begin
              failures++; $display("FAIL rand_wbsel n=%0d inst=%h got %b exp %b", n, ins, a_wb, exp_wb);
            end
          end
        end
        if (k == 1 && c != 7) begin
          checks++;
          if ({a_alu, a_imm, a_asel, a_bsel} !== {exp_alu, exp_imm, exp_asel, exp_bsel}) begin
            failures++; $display("FAIL rand_selects n=%0d inst=%h got alu=%b imm=%b a=%0b b=%0b exp alu=%b imm=%b a=%0b b=%0b",
              n, ins, a_alu, a_imm, a_asel, a_bsel, exp_alu, exp_imm, exp_asel, exp_bsel);
          end
        end
        if (k == 2 && c == 3) begin
          checks++;
          if (a_brun !== (f3[2:1] == 2'b11)) begin
            failures++; $display("FAIL rand_brun n=%0d f3=%b got %0b exp %0b", n, f3, a_brun, (f3[2:1] == 2'b11));
          end
        end
        step();
      end
      if (c == 7) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_cnt = 0;
      end else begin
        model_cnt++;
      end
    end
    mdu_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; inst = 32'h0000_0013; breq = 0; brlt = 0; mem_ready = 0; mdu_done = 0;
    test_reset();
    test_addi();
    test_branch();
    test_load_hs();
    test_mul();
    test_trap();
    test_reset_midop();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEXT_EN, default 1: 1 enables the RV32M dispatch path; 0 makes M-ops illegal.
REQ-002 Parameter MEM_HS, default 1: 1 means memory phases wait for mem_ready_i; 0 means memory phases complete in one cycle and mem_ready_i is ignored.
REQ-003 Parameter CNT_W, default 32: width of the retire counter.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk_i  in  1  sole clock, rising edge.
REQ-006 rst_i  in  1  synchronous, active-high reset.
REQ-007 inst_i  in  32  current instruction, held stable by the IR from DECODE until the next FETCH.
REQ-008 BrEq_i, BrLt_i  in  1 each  branch comparator results.
REQ-009 mem_ready_i  in  1  instruction/data memory access complete.
REQ-010 mdu_done_i  in  1  multiply/divide result valid.
REQ-011 PCWEn_o, IRWEn_o, RegWEn_o, MemRd_o, MemWr_o  out  1 each  PC, IR, register-file, data-read and data-write enables.
REQ-012 AluSel_o  out  4; ImmSel_o  out  3; WBSel_o  out  2; Asel_o, Bsel_o, BrUn_o, PCSel_o  out  1 each  datapath selects.
REQ-013 mdu_start_o  out  1  one-cycle MDU launch pulse.
REQ-014 state_o  out  3; illegal_o  out  1; retire_cnt_o  out  CNT_W  retired-instruction count.

Function
REQ-015 State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDU=5, TRAP=6. state_o reflects the current state.
REQ-016 All outputs are decoded from the state register and inst_i. Every enable not listed for a state is 0.
REQ-017 FETCH: IRWEn_o=1 while waiting. Advance to DECODE when mem_ready_i=1, or unconditionally when MEM_HS=0.
REQ-018 DECODE, illegal instruction: go to TRAP. Illegal means an opcode outside the RV32I set, or an M-op (0110011 with funct7=0000001) when MEXT_EN=0.
REQ-019 DECODE, M-op with MEXT_EN=1: pulse mdu_start_o for exactly one cycle and go to MDU.
REQ-020 DECODE, all other instructions: go to EXEC.
REQ-021 EXEC, branch (1100011): PCWEn_o=1. PCSel_o=1 iff the funct3 condition holds (BEQ/BNE on BrEq_i; BLT/BGE/BLTU/BGEU on BrLt_i). BrUn_o=1 for funct3 110/111. Next state FETCH.
REQ-022 EXEC, JAL/JALR: RegWEn_o=1, WBSel_o=10, PCSel_o=1, PCWEn_o=1. Next state FETCH.
REQ-023 EXEC, load/store: go to MEM. EXEC, all other instructions: go to WB.
REQ-024 MEM: MemRd_o (load) or MemWr_o (store) is held until mem_ready_i=1 (one cycle when MEM_HS=0). On completion, a store sets PCWEn_o=1 and goes to FETCH; a load goes to WB.
REQ-025 WB: RegWEn_o=1, PCWEn_o=1, PCSel_o=0. WBSel_o=00 for a load, 01 otherwise. Next state FETCH.
REQ-026 MDU: wait until mdu_done_i=1. In that cycle RegWEn_o=1, WBSel_o=11, PCWEn_o=1; next state FETCH.
REQ-027 mdu_done_i in any state other than MDU is ignored.
REQ-028 TRAP is absorbing: illegal_o=1, all enables 0. Only rst_i exits TRAP.
REQ-029 RegWEn_o is forced to 0 whenever rd (inst_i[11:7]) is 0.
REQ-030 AluSel_o:
- ADD (0000) for branch, JAL, JALR, load, store, AUIPC, and ADDI.
- 1111 (pass B) for LUI.
- {funct7[5],funct3} otherwise.
REQ-031 ImmSel_o: I=000, S=001, B=010, J=011, U=100, none=111.
REQ-032 Asel_o=1 for branch, JAL and AUIPC. Bsel_o=0 only for R-type.
REQ-033 retire_cnt_o increments by 1 on every cycle with PCWEn_o=1 and wraps modulo 2^CNT_W.
REQ-034 Latency with MEM_HS=0, in cycles: ALU op 4, load 5, store 4, branch/jump 3, M-op 3+MDU wait.

Reset
REQ-035 rst_i=1 at a clock edge forces state FETCH, retire_cnt_o=0 and illegal_o=0 from any state, including MEM, MDU and TRAP mid-operation.
REQ-036 While rst_i=1, all enables and mdu_start_o are 0.
REQ-037 A pending memory access or MDU operation is abandoned by reset and is not retired.

Verification
REQ-038 MEM_HS=0, inst 0x00500093 (addi x1,x0,5): states 0,1,2,4,0; RegWEn_o=1 in WB; retire_cnt_o 0->1.
REQ-039 Inst 0x00000063 (beq x0,x0) with BrEq_i=1: PCSel_o=1 and PCWEn_o=1 in EXEC. Repeat with BrEq_i=0: PCSel_o=0.
REQ-040 MEM_HS=1, inst 0x00002103 (lw x2,0(x0)), mem_ready_i low 3 cycles in MEM: MemRd_o held 4 cycles, then WB with WBSel_o=00.
REQ-041 MEXT_EN=1, inst 0x022081B3 (mul x3,x1,x2): mdu_start_o pulses once; with mdu_done_i after 5 cycles, RegWEn_o=1 and WBSel_o=11. Same inst with MEXT_EN=0: TRAP, illegal_o=1.
REQ-042 Inst 0x00000000: TRAP, illegal_o stays 1 for 10 cycles. Assert rst_i during TRAP: state_o=0, illegal_o=0, retire_cnt_o=0 on the next edge.
REQ-043 CNT_W=4: retire 17 instructions -> retire_cnt_o=1 (wrap).
